// File: rtl/pipe_pkg.sv
// Shared types, forwarding constants, state encoding and instruction decode
// for the 5-stage pipeline sequencing controller.
package pipe_pkg;

  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [1:0]       fwd_sel_t;

  localparam fwd_sel_t FWD_ID  = 2'd0;
  localparam fwd_sel_t FWD_MEM = 2'd1;
  localparam fwd_sel_t FWD_WB  = 2'd2;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_HALT
  } iclass_e;

  typedef struct packed {
    logic     valid;
    reg_idx_t dest;
    logic     is_load;
    logic     is_halt;
  } slot_t;

  typedef struct packed {
    reg_idx_t src_a;
    reg_idx_t src_b;
    reg_idx_t dest;
    iclass_e  cls;
  } dec_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Register index 0 doubles as "no operand": it can never create a hazard.
  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d.src_a = '0;
    d.src_b = '0;
    d.dest  = '0;
    d.cls   = CLS_NONE;
    if (ir != 32'h0) begin
      case (ir[31:26])
        OP_RTYPE: begin
          case (ir[5:0])
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLLV, FN_SRLV: begin
              d.src_a = ir[25:21];
              d.src_b = ir[20:16];
              d.dest  = ir[15:11];
              d.cls   = CLS_ALU;
            end
            FN_SLL, FN_SRL: begin
              d.src_a = ir[25:21];
              d.dest  = ir[15:11];
              d.cls   = CLS_ALU;
            end
            FN_JR: begin
              d.src_a = ir[25:21];
              d.cls   = CLS_JUMP;
            end
            FN_JALR: begin
              d.src_a = ir[25:21];
              d.dest  = ir[15:11];
              d.cls   = CLS_JUMP;
            end
            default: d.cls = CLS_NONE;
          endcase
        end
        OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
          d.src_a = ir[25:21];
          d.dest  = ir[20:16];
          d.cls   = CLS_ALU;
        end
        OP_LW: begin
          d.src_a = ir[25:21];
          d.dest  = ir[20:16];
          d.cls   = CLS_LOAD;
        end
        OP_SW: begin
          d.src_a = ir[25:21];
          d.src_b = ir[20:16];
          d.cls   = CLS_STORE;
        end
        OP_BEQ, OP_BNE: begin
          d.src_a = ir[25:21];
          d.cls   = CLS_BRANCH;
        end
        OP_J:    d.cls = CLS_JUMP;
        OP_JAL: begin
          d.dest = 5'd31;
          d.cls  = CLS_JUMP;
        end
        OP_HALT: d.cls = CLS_HALT;
        default: d.cls = CLS_NONE;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Three-slot destination scoreboard (EXE, MEM, WB) with hold, bubble and
// squash, plus the source-match comparators used for stalls and forwarding.
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     hold,
  input  logic     bubble,
  input  logic     squash_exe,
  input  slot_t    id_slot,
  input  reg_idx_t src_a,
  input  reg_idx_t src_b,
  output logic     exe_hit_a,
  output logic     exe_hit_b,
  output logic     mem_hit_a,
  output logic     mem_hit_b,
  output logic     exe_load,
  output logic     exe_halt,
  output logic     mem_halt
);

  slot_t exe_q, mem_q, wb_q;
  slot_t exe_d, mem_d, wb_d;

  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!hold) begin
      wb_d  = mem_q;
      mem_d = squash_exe ? '0 : exe_q;
      exe_d = bubble ? '0 : id_slot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  function automatic logic hit(input slot_t s, input reg_idx_t src);
    return s.valid && (s.dest != '0) && (src == s.dest) && (int'(s.dest) < NREG);
  endfunction

  assign exe_hit_a = hit(exe_q, src_a);
  assign exe_hit_b = hit(exe_q, src_b);
  assign mem_hit_a = hit(mem_q, src_a);
  assign mem_hit_b = hit(mem_q, src_b);
  assign exe_load  = exe_q.valid && exe_q.is_load;
  assign exe_halt  = exe_q.valid && exe_q.is_halt;
  assign mem_halt  = mem_q.valid && mem_q.is_halt;

  // The WB slot only exists so the pipe depth is tracked; nothing reads it.
  logic unused_wb;
  assign unused_wb = ^wb_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall, bubble, flush, forwarding and HALT-drain control for the 5-stage core.
// Define HAZARD_FORWARD_EN to enable forwarding (only load-use then stalls).
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ir_id,
  input  logic             id_valid,
  input  logic             branch_taken,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_exe,
  output logic             flush_id,
  output logic [1:0]       fwd_x,
  output logic [1:0]       fwd_y,
  output logic             halted
);

  dec_t     dec;
  slot_t    id_slot;
  state_e   state_q, state_d;
  fwd_sel_t fwd_x_q, fwd_x_d, fwd_y_q, fwd_y_d;
  logic     exe_hit_a, exe_hit_b, mem_hit_a, mem_hit_b;
  logic     exe_load, exe_halt, mem_halt;
  logic     raw_hazard, sb_hold, sb_bubble, squash_exe;

  assign dec = decode(ir_id[31:0]);

  always_comb begin
    id_slot         = '0;
    id_slot.valid   = 1'b1;
    id_slot.dest    = dec.dest;
    id_slot.is_load = (dec.cls == CLS_LOAD);
    id_slot.is_halt = (dec.cls == CLS_HALT);
  end

  assign sb_hold    = (state_q == HALTED);
  assign sb_bubble  = bubble_exe || flush_id || !id_valid;
  assign squash_exe = (state_q == DRAIN) && branch_taken && exe_halt;

  pipe_scoreboard #(.NREG(NREG)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .hold      (sb_hold),
    .bubble    (sb_bubble),
    .squash_exe(squash_exe),
    .id_slot   (id_slot),
    .src_a     (dec.src_a),
    .src_b     (dec.src_b),
    .exe_hit_a (exe_hit_a),
    .exe_hit_b (exe_hit_b),
    .mem_hit_a (mem_hit_a),
    .mem_hit_b (mem_hit_b),
    .exe_load  (exe_load),
    .exe_halt  (exe_halt),
    .mem_halt  (mem_halt)
  );

`ifdef HAZARD_FORWARD_EN
  assign raw_hazard = exe_load && (exe_hit_a || exe_hit_b);

  // The select travels with the ID instruction, so only an advancing one sets it.
  always_comb begin
    fwd_x_d = FWD_ID;
    fwd_y_d = FWD_ID;
    if (!sb_bubble && !sb_hold) begin
      if (exe_hit_a)      fwd_x_d = FWD_MEM;
      else if (mem_hit_a) fwd_x_d = FWD_WB;
      if (exe_hit_b)      fwd_y_d = FWD_MEM;
      else if (mem_hit_b) fwd_y_d = FWD_WB;
    end
  end
`else
  assign raw_hazard = exe_hit_a || exe_hit_b || mem_hit_a || mem_hit_b;

  always_comb begin
    fwd_x_d = FWD_ID;
    fwd_y_d = FWD_ID;
  end

  logic unused_fwd;
  assign unused_fwd = exe_load;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fwd_x_q <= FWD_ID;
      fwd_y_q <= FWD_ID;
    end else begin
      state_q <= state_d;
      fwd_x_q <= fwd_x_d;
      fwd_y_q <= fwd_y_d;
    end
  end

  // A taken branch seen while the HALT is in EXE is older, so the HALT dies.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (id_valid && (dec.cls == CLS_HALT) && !branch_taken) state_d = DRAIN;
      end
      DRAIN: begin
        if (branch_taken && exe_halt) state_d = RUN;
        else if (mem_halt)            state_d = HALTED;
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    bubble_exe = 1'b0;
    flush_id   = 1'b0;
    halted     = 1'b0;
    if (state_q == HALTED) begin
      halted   = 1'b1;
      stall_if = 1'b1;
      stall_id = 1'b1;
    end else if (branch_taken) begin
      flush_id   = 1'b1;
      bubble_exe = 1'b1;
    end else if (state_q == DRAIN) begin
      stall_if   = 1'b1;
      flush_id   = 1'b1;
      bubble_exe = 1'b1;
    end else if (id_valid && raw_hazard) begin
      stall_if   = 1'b1;
      stall_id   = 1'b1;
      bubble_exe = 1'b1;
    end
  end

  assign fwd_x = fwd_x_q;
  assign fwd_y = fwd_y_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver queues expected outputs,
// a monitor on the falling edge pops and compares them cycle by cycle.
module tb_pipe_hazard_ctrl;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ir_id = '0;
   logic        id_valid = 1'b0;
   logic        branch_taken = 1'b0;
   logic        stall_if, stall_id, bubble_exe, flush_id, halted;
   logic [1:0]  fwd_x, fwd_y;

   int total = 0;
   int bad   = 0;

   string      name_q[$];
   logic [8:0] exp_q[$];
   logic [8:0] mask_q[$];

   // Output vector bits: stall_if, stall_id, bubble_exe, flush_id, fwd_x[2], fwd_y[2], halted
   localparam logic [8:0] MC = 9'b111100000;
   localparam logic [8:0] MH = 9'b000000001;
   localparam logic [8:0] MA = 9'b111111111;
   localparam logic [8:0] MD = 9'b100100001;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.WIDTH(32), .NREG(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .ir_id       (ir_id),
      .id_valid    (id_valid),
      .branch_taken(branch_taken),
      .stall_if    (stall_if),
      .stall_id    (stall_id),
      .bubble_exe  (bubble_exe),
      .flush_id    (flush_id),
      .fwd_x       (fwd_x),
      .fwd_y       (fwd_y),
      .halted      (halted)
   );

   function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rs, input int rt, input int rd);
      return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [8:0] ex(input int si, input int sd, input int bu, input int fl,
                                     input int fx, input int fy, input int h);
      return {1'(si), 1'(sd), 1'(bu), 1'(fl), 2'(fx), 2'(fy), 1'(h)};
   endfunction

   // Drive one cycle of inputs and queue what the outputs must be in that cycle.
   task automatic applyStimulus(input int r, input logic [31:0] ir, input int v, input int br,
                                input string nm, input logic [8:0] e, input logic [8:0] m);
      @(posedge clk);
      #1;
      rst          = 1'(r);
      ir_id        = ir;
      id_valid     = 1'(v);
      branch_taken = 1'(br);
      name_q.push_back(nm);
      exp_q.push_back(e);
      mask_q.push_back(m);
   endtask

   task automatic idle(input int n, input string nm);
      for (int i = 0; i < n; i++) applyStimulus(0, 32'h0, 0, 0, nm, 9'h0, MC | MH);
   endtask

   task automatic checkOutput(input string nm, input logic [8:0] e, input logic [8:0] m);
      logic [8:0] act;
      act = {stall_if, stall_id, bubble_exe, flush_id, fwd_x, fwd_y, halted};
      total++;
      if ((act & m) !== (e & m)) begin
         bad++;
         $display("[TB] FAIL %s: got=%b want=%b mask=%b", nm, act & m, e & m, m);
      end
   endtask

   // Monitor: one queued expectation per cycle, compared mid-cycle.
   always @(negedge clk) begin
      string      nm;
      logic [8:0] e, m;
      if (exp_q.size() != 0) begin
         nm = name_q.pop_front();
         e  = exp_q.pop_front();
         m  = mask_q.pop_front();
         if (m != 9'h0) checkOutput(nm, e, m);
      end
   end

   initial begin
      logic [31:0] add_3_1_2, add_4_3_3, add_10_1_2, lw_5, sub_6_5_7, add_9_6_6;
      logic [31:0] add_0_1_2, lw_0, or_4_0_0, add_1_2_3, add_2_4_5, add_7_1_1;
      logic [31:0] add_8_1_2, halt_i, bne_i;
      add_3_1_2  = enc_r(FN_ADD, 1, 2, 3);
      add_4_3_3  = enc_r(FN_ADD, 3, 3, 4);
      add_10_1_2 = enc_r(FN_ADD, 1, 2, 10);
      lw_5       = enc_i(OP_LW, 1, 5, 4);
      sub_6_5_7  = enc_r(FN_SUB, 5, 7, 6);
      add_9_6_6  = enc_r(FN_ADD, 6, 6, 9);
      add_0_1_2  = enc_r(FN_ADD, 1, 2, 0);
      lw_0       = enc_i(OP_LW, 1, 0, 0);
      or_4_0_0   = enc_r(FN_OR, 0, 0, 4);
      add_1_2_3  = enc_r(FN_ADD, 2, 3, 1);
      add_2_4_5  = enc_r(FN_ADD, 4, 5, 2);
      add_7_1_1  = enc_r(FN_ADD, 1, 1, 7);
      add_8_1_2  = enc_r(FN_ADD, 1, 2, 8);
      halt_i     = {OP_HALT, 26'd0};
      bne_i      = enc_i(OP_BNE, 1, 2, 8);

      $display("[TB] start");
      applyStimulus(1, 32'h0, 0, 0, "reset_hold", 9'h0, 9'h0);
      applyStimulus(0, 32'h0, 0, 0, "reset_state", 9'h0, MA);

      // Back-to-back ALU dependency
      applyStimulus(0, add_3_1_2, 1, 0, "b2b_prod", 9'h0, MA);
`ifdef HAZARD_FORWARD_EN
      applyStimulus(0, add_4_3_3, 1, 0, "b2b_cons_nostall", 9'h0, MA);
      applyStimulus(0, 32'h0, 0, 0, "b2b_fwd_exe", ex(0,0,0,0,1,1,0), MA);
`else
      applyStimulus(0, add_4_3_3, 1, 0, "b2b_stall1", ex(1,1,1,0,0,0,0), MA);
      applyStimulus(0, add_4_3_3, 1, 0, "b2b_stall2", ex(1,1,1,0,0,0,0), MA);
      applyStimulus(0, add_4_3_3, 1, 0, "b2b_release", 9'h0, MA);
      applyStimulus(0, 32'h0, 0, 0, "b2b_fwd_zero", 9'h0, MA);
`endif
      idle(3, "idle_a");

      // One independent instruction between producer and consumer
      applyStimulus(0, add_3_1_2, 1, 0, "gap_prod", 9'h0, MA);
      applyStimulus(0, add_10_1_2, 1, 0, "gap_mid", 9'h0, MA);
`ifdef HAZARD_FORWARD_EN
      applyStimulus(0, add_4_3_3, 1, 0, "gap_cons_nostall", 9'h0, MA);
      applyStimulus(0, 32'h0, 0, 0, "gap_fwd_wb", ex(0,0,0,0,2,2,0), MA);
`else
      applyStimulus(0, add_4_3_3, 1, 0, "gap_stall", ex(1,1,1,0,0,0,0), MA);
      applyStimulus(0, add_4_3_3, 1, 0, "gap_release", 9'h0, MA);
`endif
      idle(3, "idle_b");

      // Load-use
      applyStimulus(0, lw_5, 1, 0, "lu_load", 9'h0, MA);
      applyStimulus(0, sub_6_5_7, 1, 0, "lu_stall1", ex(1,1,1,0,0,0,0), MA);
`ifdef HAZARD_FORWARD_EN
      applyStimulus(0, sub_6_5_7, 1, 0, "lu_release", 9'h0, MA);
      applyStimulus(0, 32'h0, 0, 0, "lu_fwd_wb", ex(0,0,0,0,2,0,0), MA);
`else
      applyStimulus(0, sub_6_5_7, 1, 0, "lu_stall2", ex(1,1,1,0,0,0,0), MA);
      applyStimulus(0, sub_6_5_7, 1, 0, "lu_release", 9'h0, MA);
      applyStimulus(0, 32'h0, 0, 0, "lu_fwd_zero", 9'h0, MA);
`endif
      idle(3, "idle_c");

      // Taken branch beats a pending load-use stall; the SUB never issues
      applyStimulus(0, lw_5, 1, 0, "br_load", 9'h0, MA);
      applyStimulus(0, sub_6_5_7, 1, 1, "br_flush", ex(0,0,1,1,0,0,0), MA);
      applyStimulus(0, add_9_6_6, 1, 0, "br_target", 9'h0, MA);
      applyStimulus(0, 32'h0, 0, 0, "br_target_fwd", 9'h0, MA);
      idle(3, "idle_d");

      // r0 never creates a hazard
      applyStimulus(0, add_0_1_2, 1, 0, "r0_alu_prod", 9'h0, MA);
      applyStimulus(0, or_4_0_0, 1, 0, "r0_alu_cons", 9'h0, MA);
      applyStimulus(0, lw_0, 1, 0, "r0_load_prod", 9'h0, MA);
      applyStimulus(0, or_4_0_0, 1, 0, "r0_load_cons", 9'h0, MA);
      applyStimulus(0, 32'h0, 0, 0, "r0_fwd", 9'h0, MA);
      idle(3, "idle_e");

      // Reset in the middle of a stall
      applyStimulus(0, lw_5, 1, 0, "rs_load", 9'h0, MA);
      applyStimulus(0, sub_6_5_7, 1, 0, "rs_stall", ex(1,1,1,0,0,0,0), MA);
      applyStimulus(1, sub_6_5_7, 1, 0, "rs_reset", 9'h0, 9'h0);
      applyStimulus(0, sub_6_5_7, 1, 0, "rs_cleared", 9'h0, MA);
      applyStimulus(0, 32'h0, 0, 0, "rs_fwd", 9'h0, MA);
      idle(3, "idle_f");

      // HALT after two ALU instructions, then reset out of HALTED
      applyStimulus(0, add_1_2_3, 1, 0, "h_alu1", 9'h0, MC | MH);
      applyStimulus(0, add_2_4_5, 1, 0, "h_alu2", 9'h0, MC | MH);
      applyStimulus(0, halt_i, 1, 0, "h_halt_id", 9'h0, MC | MH);
      applyStimulus(0, add_7_1_1, 1, 0, "h_drain1", ex(1,0,0,1,0,0,0), MD);
      applyStimulus(0, add_7_1_1, 1, 0, "h_drain2", ex(1,0,0,1,0,0,0), MD);
      applyStimulus(0, add_7_1_1, 1, 0, "h_halted", ex(1,1,0,0,0,0,1), MC | MH);
      applyStimulus(0, 32'h0, 0, 0, "h_sticky", ex(1,1,0,0,0,0,1), MC | MH);
      applyStimulus(1, 32'h0, 0, 0, "h_reset", 9'h0, 9'h0);
      applyStimulus(0, 32'h0, 0, 0, "h_after_reset", 9'h0, MA);
      applyStimulus(0, add_1_2_3, 1, 0, "h_run_again", 9'h0, MC | MH);
      idle(3, "idle_g");

      // Taken branch while HALT is in ID: the HALT is flushed
      applyStimulus(0, bne_i, 1, 0, "bh_branch_id", 9'h0, MA);
      applyStimulus(0, halt_i, 1, 1, "bh_flush", ex(0,0,1,1,0,0,0), MA);
      applyStimulus(0, add_8_1_2, 1, 0, "bh_target", 9'h0, MC | MH);
      idle(4, "bh_no_halt");

      // Taken branch while HALT is in EXE: DRAIN returns to RUN
      applyStimulus(0, halt_i, 1, 0, "be_halt_id", 9'h0, MC | MH);
      applyStimulus(0, add_8_1_2, 1, 1, "be_squash", ex(0,0,1,1,0,0,0), MA);
      applyStimulus(0, add_1_2_3, 1, 0, "be_target", 9'h0, MC | MH);
      idle(4, "be_no_halt");

      for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain_queue: got=%0d pending want=0 pending", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage core (IF, ID, EXE, MEM, WB). It decodes the instruction in ID and keeps an internal scoreboard of destination registers for EXE, MEM and WB. From these it produces the stall, bubble, flush and forwarding controls that drive `IsStall` and the operand muxes in front of EXE. It also drains the pipe on `HALT`.

## Interface
- `WIDTH`: from `params.v`, default 32; instruction width.
- `NREG`: default 32; architectural registers (5-bit index); r0 is hard-wired zero.
- `clk` in 1: pipeline clock.
- `rst` in 1: synchronous, active-high reset.
- `ir_id` in `WIDTH`: instruction currently in ID.
- `id_valid` in 1: `ir_id` holds a real instruction (0 = bubble).
- `branch_taken` in 1: `IsBranchTaken` from EXE, same cycle.
- `stall_if` out 1: hold PC and the IF/ID register.
- `stall_id` out 1: hold the ID stage; drives EXE `IsStall`.
- `bubble_exe` out 1: load a NOP into the ID/EXE register this edge.
- `flush_id` out 1: replace the IF/ID contents with a bubble this edge.
- `fwd_x` out 2: registered select for the EXE X operand. 0 = ID value, 1 = MEM-stage Z, 2 = WB write data.
- `fwd_y` out 2: registered select for the EXE Y operand, same encoding.
- `halted` out 1: the pipe has drained after `HALT`; sticky until reset.

## Operation
- Decode (package function) of `ir_id` yields:
  - src_a = rs [25:21] for ALU, shift, load, store, branch, `JR`, `JALR`.
  - src_b = rt [20:16] for R-type ALU, `SLLV`, `SRLV` and stores.
  - dest = rd [15:11] for R-type; rt for `ADDI`, `ANDI`, `ORI`, `LUI`, loads; 31 for `JAL`.
  - none for stores, branches, `J`, `JR`, `NOP`, `HALT`.
  - Index 0 never creates a hazard.
- Scoreboard: three slots (EXE, MEM, WB), each {valid, dest[4:0], is_load, is_halt}. On every non-held edge: WB ← MEM, MEM ← EXE, EXE ← ID entry. The EXE slot takes a bubble when `bubble_exe`, `flush_id`, or `id_valid` = 0.
- Hazard with `FORWARD_EN`: the EXE slot is a load, valid, and its dest equals src_a or src_b of ID. Result: load-use stall, exactly 1 cycle.
- Hazard without `FORWARD_EN`: any valid EXE or MEM slot dest matches src_a or src_b of ID. Result: stall until the producer reaches WB. The register file writes in the first half-cycle, so WB needs no stall.
- On a stall: `stall_if` = `stall_id` = `bubble_exe` = 1.
- Forwarding (`FORWARD_EN` only): computed on the ID instruction as it advances and registered with it.
  - The EXE-slot match wins over the MEM-slot match.
  - On an EXE-slot match (non-load), the select is 1 next cycle.
  - On a MEM-slot match, the select is 2.
  - Otherwise the select is 0.
- Branch: `branch_taken` = 1 forces `flush_id` = 1 and `bubble_exe` = 1. The IF/ID and ID instructions are discarded, giving a 2-cycle penalty. `branch_taken` has priority over any stall and clears the stall that cycle. `stall_if` = 0 so the PC loads the target.
- State machine `{RUN, DRAIN, HALTED}`:
  - RUN → DRAIN when `HALT` is in ID, `id_valid` = 1 and there is no `branch_taken`. The HALT enters the EXE slot.
  - In DRAIN: `stall_if` = 1 and `flush_id` = 1 every cycle, and younger instructions become bubbles.
  - DRAIN → RUN if `branch_taken` = 1 while HALT is still in EXE. That branch is older than the HALT, so the HALT is squashed and the slot is cleared.
  - DRAIN → HALTED when the HALT slot reaches WB.
  - In HALTED: `halted` = 1, `stall_if` = `stall_id` = 1, and the scoreboard freezes.
- Reset values:
  - `stall_if` = `stall_id` = `bubble_exe` = `flush_id` = 0.
  - `fwd_x` = `fwd_y` = 0, `halted` = 0.
  - All slots invalid; state = RUN.
  - Reset asserted mid-stall or mid-DRAIN overrides everything on that edge.

## Timing
- The stall, bubble and flush outputs are combinational from `ir_id`, the scoreboard and `branch_taken`, and are valid in the same cycle.
- `fwd_x` and `fwd_y` are registered and valid during the cycle the consumer is in EXE.
- Load-use with `FORWARD_EN`: consumer in ID at cycle n is stalled at n. It enters EXE at n+2 with select 2.
- Without `FORWARD_EN`, a dependent pair with one instruction between producer and consumer costs 1 stall cycle; back-to-back costs 2.
- `halted` rises 3 edges after HALT leaves ID (EXE, MEM, WB).

## Configuration
- `HAZARD_FORWARD_EN`:
  - Defined: forwarding paths are active; the only stall is load-use.
  - Undefined: `fwd_x` and `fwd_y` are tied to 0, and the controller stalls on every RAW hazard against the EXE and MEM slots.

## Structure
- The shared package `pipe_pkg` holds:
  - The slot struct {valid, dest, is_load, is_halt}.
  - The `FWD_ID`, `FWD_MEM`, `FWD_WB` constants.
  - The state encoding.
  - The decode function mapping the `ISA.v` opcodes to src_a, src_b, dest and class.
- One sub-module, `pipe_scoreboard`: a 3-slot shift register with hold, bubble and clear. It also provides the match comparators for the two sources.

## Test plan
- `ADD` r3,r1,r2 then `ADD` r4,r3,r3:
  - With the macro: no stall, `fwd_x` = `fwd_y` = 1 in the consumer's EXE cycle.
  - Without the macro: 2 stall cycles.
- `LW` r5 then `SUB` r6,r5,r7: exactly 1 stall cycle, then `fwd_x` = 2 and `fwd_y` = 0.
- `BEQ` taken in EXE while a load-use stall is pending in ID: `flush_id` = 1, `bubble_exe` = 1, `stall_if` = 0 in the same cycle; the stalled instruction is never issued.
- Writes to r0 followed by reads of r0: never a stall, and forwarding stays 0.
- `HALT` with 2 preceding ALU instructions: `stall_if` rises the next cycle and `halted` = 1 after 3 edges. Then `rst` for 1 cycle returns all outputs to 0 and the state to RUN.
- `BNE` taken in EXE while `HALT` is in ID: the HALT is flushed, the state stays RUN and `halted` stays 0.
